// File: rtl/addb_seq_pkg.sv
// Shared definitions for the address-adder sequencer: the state set,
// the encodings of the two adder operand selects, and the rule that picks
// the next enabled step state at the end of an inner loop.
package addb_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PIX,
    ST_INC1,
    ST_INC2,
    ST_STF,
    ST_STI,
    ST_ST2,
    ST_RELOAD,
    ST_DONE
  } state_e;

  // addb mux select (B operand). Code 3 also selects A1 in the datapath,
  // but this block never drives it.
  localparam logic [1:0] ADDB_A1  = 2'd0;
  localparam logic [1:0] ADDB_A2  = 2'd1;
  localparam logic [1:0] ADDB_A1F = 2'd2;

  // A operand select.
  localparam logic [2:0] ADDA_A1_PIX   = 3'd0;
  localparam logic [2:0] ADDA_A2_PIX   = 3'd1;
  localparam logic [2:0] ADDA_A1F_STEP = 3'd2;
  localparam logic [2:0] ADDA_A1_STEP  = 3'd3;
  localparam logic [2:0] ADDA_A2_STEP  = 3'd4;

  // Step states run in the fixed order STF, STI, ST2; disabled ones are
  // skipped entirely. Called from INC2 (nothing done yet) or from a step
  // state; when no enabled step remains the sequence ends in RELOAD.
  function automatic state_e next_step(input state_e cur,
                                       input logic en_f,
                                       input logic en_i,
                                       input logic en_2);
    state_e nxt;
    nxt = ST_RELOAD;
    case (cur)
      ST_STF: begin
        if (en_i)      nxt = ST_STI;
        else if (en_2) nxt = ST_ST2;
      end
      ST_STI: begin
        if (en_2) nxt = ST_ST2;
      end
      ST_ST2: nxt = ST_RELOAD;
      default: begin
        if (en_f)      nxt = ST_STF;
        else if (en_i) nxt = ST_STI;
        else if (en_2) nxt = ST_ST2;
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/addb_seq_if.sv
// Command/handshake bundle between the blitter command registers, the
// sequencer and the address datapath. The sequencer is the slave side.
interface addb_seq_if #(
  parameter int CW = 16
);
  logic          start;
  logic          abort;
  logic [CW-1:0] inner_count;
  logic [CW-1:0] outer_count;
  logic          upda1f;
  logic          upda1;
  logic          upda2;
  logic          pix_ack;
  logic [1:0]    addbsel;
  logic [2:0]    addasel;
  logic          frac_cy_en;
  logic          a1_ld;
  logic          a1f_ld;
  logic          a2_ld;
  logic          busy;
  logic          done;
  logic [CW-1:0] inner_rem;

  modport master (
    output start, abort, inner_count, outer_count, upda1f, upda1, upda2, pix_ack,
    input  addbsel, addasel, frac_cy_en, a1_ld, a1f_ld, a2_ld, busy, done, inner_rem
  );

  modport slave (
    input  start, abort, inner_count, outer_count, upda1f, upda1, upda2, pix_ack,
    output addbsel, addasel, frac_cy_en, a1_ld, a1f_ld, a2_ld, busy, done, inner_rem
  );
endinterface

// File: rtl/addb_seq_loop_cnt.sv
// Loadable down-counter with a zero flag. Load wins over decrement, and a
// decrement at zero is ignored so the count can never wrap.
module loop_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  // Count register: reset, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (!resetl) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/addb_seq.sv
// Address-adder sequencer. Issues the A1/A2 pixel-increment adds for each
// acknowledged pixel and the optional A1-fraction, A1 and A2 step adds at
// every inner-loop end except the last. All outputs are registered and
// decoded from the next state, so they line up with the state register.
module addb_seq
  import addb_seq_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic         sys_clk,
  input  logic         resetl,
  addb_seq_if.slave    bus
);

  localparam int N_CNT = 2;  // counter 0: inner loop, counter 1: outer loop

  state_e state_reg, state_next;

  logic [CW-1:0] inner_len_reg;
  logic          upda1f_reg, upda1_reg, upda2_reg;

  logic [N_CNT-1:0] cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_load_val [N_CNT];
  logic [CW-1:0]    cnt_value    [N_CNT];

  logic [1:0] addbsel_reg, addbsel_next;
  logic [2:0] addasel_reg, addasel_next;
  logic       frac_cy_en_reg, frac_cy_en_next;
  logic       a1_ld_reg, a1_ld_next;
  logic       a1f_ld_reg, a1f_ld_next;
  logic       a2_ld_reg, a2_ld_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  logic start_ok, counts_zero, inner_last, outer_last;

  genvar gi;
  generate
    for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
      loop_cnt #(.CW(CW)) u_cnt (
        .clk      (sys_clk),
        .resetl   (resetl),
        .load     (cnt_load[gi]),
        .load_val (cnt_load_val[gi]),
        .dec      (cnt_dec[gi]),
        .count    (cnt_value[gi]),
        .zero     (cnt_zero[gi])
      );
    end
  endgenerate

  assign start_ok    = (state_reg == ST_IDLE) && bus.start && !bus.abort;
  assign counts_zero = (bus.inner_count == '0) || (bus.outer_count == '0);
  // The decrement taken in INC2 brings the counter to zero.
  assign inner_last  = (cnt_value[0] == CW'(1));
  assign outer_last  = (cnt_value[1] == CW'(1));

  // Command latch: inner length for RELOAD and the three step enables.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      inner_len_reg <= '0;
      upda1f_reg    <= 1'b0;
      upda1_reg     <= 1'b0;
      upda2_reg     <= 1'b0;
    end else if (start_ok) begin
      inner_len_reg <= bus.inner_count;
      upda1f_reg    <= bus.upda1f;
      upda1_reg     <= bus.upda1;
      upda2_reg     <= bus.upda2;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!resetl) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next state, counter control and next-cycle output decode.
  always_comb begin
    state_next      = state_reg;
    cnt_load        = '0;
    cnt_dec         = '0;
    cnt_load_val[0] = '0;
    cnt_load_val[1] = '0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start && !counts_zero) begin
          state_next      = ST_PIX;
          cnt_load        = '1;
          cnt_load_val[0] = bus.inner_count;
          cnt_load_val[1] = bus.outer_count;
        end
      end
      ST_PIX:  if (bus.pix_ack) state_next = ST_INC1;
      ST_INC1: state_next = ST_INC2;
      ST_INC2: begin
        cnt_dec[0] = !cnt_zero[0];
        if (!inner_last) begin
          state_next = ST_PIX;
        end else begin
          cnt_dec[1] = !cnt_zero[1];
          if (outer_last) state_next = ST_DONE;
          else            state_next = next_step(ST_INC2, upda1f_reg, upda1_reg, upda2_reg);
        end
      end
      ST_STF, ST_STI, ST_ST2: begin
        state_next = next_step(state_reg, upda1f_reg, upda1_reg, upda2_reg);
      end
      ST_RELOAD: state_next = ST_PIX;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    // Refill the inner counter as RELOAD is entered so the next pixel
    // loop starts from the full length.
    if (state_next == ST_RELOAD) begin
      cnt_load[0]     = 1'b1;
      cnt_load_val[0] = inner_len_reg;
    end

    // Abort overrides everything, including a start in the same cycle.
    if (bus.abort) begin
      state_next      = ST_IDLE;
      cnt_load        = '1;
      cnt_load_val[0] = '0;
      cnt_load_val[1] = '0;
      cnt_dec         = '0;
    end

    addbsel_next    = ADDB_A1;
    addasel_next    = ADDA_A1_PIX;
    frac_cy_en_next = 1'b0;
    a1_ld_next      = 1'b0;
    a1f_ld_next     = 1'b0;
    a2_ld_next      = 1'b0;
    case (state_next)
      ST_INC1: begin
        a1_ld_next = 1'b1;
      end
      ST_INC2: begin
        addbsel_next = ADDB_A2;
        addasel_next = ADDA_A2_PIX;
        a2_ld_next   = 1'b1;
      end
      ST_STF: begin
        addbsel_next = ADDB_A1F;
        addasel_next = ADDA_A1F_STEP;
        a1f_ld_next  = 1'b1;
      end
      ST_STI: begin
        addbsel_next    = ADDB_A1;
        addasel_next    = ADDA_A1_STEP;
        a1_ld_next      = 1'b1;
        frac_cy_en_next = upda1f_reg;
      end
      ST_ST2: begin
        addbsel_next = ADDB_A2;
        addasel_next = ADDA_A2_STEP;
        a2_ld_next   = 1'b1;
      end
      default: ;
    endcase

    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_DONE) || (start_ok && counts_zero);
  end

  // Output registers.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      addbsel_reg    <= ADDB_A1;
      addasel_reg    <= ADDA_A1_PIX;
      frac_cy_en_reg <= 1'b0;
      a1_ld_reg      <= 1'b0;
      a1f_ld_reg     <= 1'b0;
      a2_ld_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      addbsel_reg    <= addbsel_next;
      addasel_reg    <= addasel_next;
      frac_cy_en_reg <= frac_cy_en_next;
      a1_ld_reg      <= a1_ld_next;
      a1f_ld_reg     <= a1f_ld_next;
      a2_ld_reg      <= a2_ld_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign bus.addbsel    = addbsel_reg;
  assign bus.addasel    = addasel_reg;
  assign bus.frac_cy_en = frac_cy_en_reg;
  assign bus.a1_ld      = a1_ld_reg;
  assign bus.a1f_ld     = a1f_ld_reg;
  assign bus.a2_ld      = a2_ld_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.inner_rem  = cnt_value[0];

endmodule
